// File: rtl/ysyx_25030093_lsu.sv
// Load/store unit between EXU and WBU: one instruction in flight, valid/ready memory bus,
// load alignment/extension, store lane replication, single-packet write-back handshake.
module ysyx_25030093_lsu #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_mem_op,
    input  logic [2:0]            in_funct3,
    input  logic [DATA_WIDTH-1:0] in_alu_result,
    input  logic [DATA_WIDTH-1:0] in_store_data,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_wen,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic                  mem_wen,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_rdata,
    input  logic                  mem_rsp_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic                  wb_wen,
    output logic                  lsu_fault
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]            state;
    logic                  store_q;
    logic [2:0]            funct3_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] sdata_q;
    logic                  wen_q;

    logic                  in_is_mem;
    logic                  in_is_store;
    logic                  in_f3_legal;
    logic                  in_misaligned;
    logic [DATA_WIDTH-1:0] lane;
    logic [DATA_WIDTH-1:0] load_data;
    logic [3:0]            strb;
    logic [DATA_WIDTH-1:0] wdata;

    assign in_ready      = (state == S_IDLE);
    assign mem_req_valid = (state == S_REQ);
    assign out_valid     = (state == S_DONE);
    assign mem_addr      = addr_q;
    assign mem_wen       = store_q;
    assign mem_wdata     = wdata;
    assign mem_wstrb     = store_q ? strb : 4'b0000;

    // Reserved op 2'b11 falls through as a non-memory instruction.
    assign in_is_mem   = (in_mem_op == 2'b01) || (in_mem_op == 2'b10);
    assign in_is_store = (in_mem_op == 2'b10);

    always_comb begin
        in_f3_legal = 1'b0;
        if (in_is_store)
            in_f3_legal = !in_funct3[2] && (in_funct3[1:0] != 2'b11);
        else
            in_f3_legal = (in_funct3[1:0] != 2'b11) && !(in_funct3[2] && in_funct3[1]);
    end

    always_comb begin
        in_misaligned = 1'b0;
        if (in_funct3[1:0] == 2'b01)
            in_misaligned = in_alu_result[0];
        else if (in_funct3[1:0] == 2'b10)
            in_misaligned = (in_alu_result[1:0] != 2'b00);
    end

    assign lane = mem_rsp_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_data = lane;
        case (funct3_q[1:0])
            2'b00:   load_data = {{24{lane[7] & ~funct3_q[2]}}, lane[7:0]};
            2'b01:   load_data = {{16{lane[15] & ~funct3_q[2]}}, lane[15:0]};
            default: load_data = lane;
        endcase
    end

    always_comb begin
        strb  = 4'b1111;
        wdata = sdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                strb  = 4'b0001 << addr_q[1:0];
                wdata = {4{sdata_q[7:0]}};
            end
            2'b01: begin
                strb  = 4'b0011 << addr_q[1:0];
                wdata = {2{sdata_q[15:0]}};
            end
            default: begin
                strb  = 4'b1111;
                wdata = sdata_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            store_q   <= 1'b0;
            funct3_q  <= '0;
            addr_q    <= '0;
            sdata_q   <= '0;
            wen_q     <= 1'b0;
            wb_data   <= '0;
            wb_addr   <= '0;
            wb_wen    <= 1'b0;
            lsu_fault <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        store_q  <= in_is_store;
                        funct3_q <= in_funct3;
                        addr_q   <= in_alu_result;
                        sdata_q  <= in_store_data;
                        wen_q    <= in_wen;
                        wb_addr  <= in_rd;
                        wb_data  <= in_alu_result;
                        if (!in_is_mem) begin
                            wb_wen    <= in_wen && (in_rd != '0);
                            lsu_fault <= 1'b0;
                            state     <= S_DONE;
                        end else if (!in_f3_legal || in_misaligned) begin
                            wb_wen    <= 1'b0;
                            lsu_fault <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            wb_wen    <= 1'b0;
                            lsu_fault <= 1'b0;
                            state     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        wb_data   <= store_q ? '0 : load_data;
                        wb_wen    <= wen_q && (wb_addr != '0) && !store_q && !mem_rsp_err;
                        lsu_fault <= mem_rsp_err;
                        state     <= S_DONE;
                    end
                end
                default: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25030093_lsu.sv
// Scoreboard bench for ysyx_25030093_lsu: driver pushes expected requests/packets,
// memory and WBU monitors pop and compare at handshakes.
module tb_ysyx_25030093_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mem_op;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        mem_rsp_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_addr;
    logic        wb_wen;
    logic        lsu_fault;

    ysyx_25030093_lsu #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mem_op(in_mem_op), .in_funct3(in_funct3),
        .in_alu_result(in_alu_result), .in_store_data(in_store_data), .in_rd(in_rd), .in_wen(in_wen),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
        .out_valid(out_valid), .out_ready(out_ready), .wb_data(wb_data), .wb_addr(wb_addr),
        .wb_wen(wb_wen), .lsu_fault(lsu_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wen;
        logic        fault;
        logic        chk_data;
    } out_t;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        chk_wdata;
    } req_t;

    out_t exp_out[$];
    req_t exp_req[$];

    int tests = 0;
    int fails = 0;
    int n_done = 0;
    int req_delay = 0;
    int rsp_delay = 1;
    int out_stall = 0;
    logic [31:0] rsp_data = '0;
    logic        rsp_err  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory side: stalls ready, checks request stability and contents, returns one response.
    initial begin
        int   wait_cnt;
        int   rsp_cnt;
        bit   rsp_pend;
        req_t hold;
        req_t e;
        wait_cnt = 0; rsp_cnt = 0; rsp_pend = 0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; mem_rsp_err = 1'b0;
        forever begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            mem_rsp_err   = 1'b0;
            if (mem_req_ready) begin
                mem_req_ready = 1'b0;
                wait_cnt = 0;
                rsp_pend = 1;
                rsp_cnt  = 0;
            end else if (mem_req_valid) begin
                if (wait_cnt == 0) begin
                    hold.addr = mem_addr; hold.wen = mem_wen;
                    hold.wdata = mem_wdata; hold.wstrb = mem_wstrb;
                end else begin
                    chk("req hold addr", mem_addr, hold.addr);
                    chk("req hold wdata", mem_wdata, hold.wdata);
                    chk("req hold wstrb", {28'd0, mem_wstrb}, {28'd0, hold.wstrb});
                end
                if (wait_cnt >= req_delay) begin
                    mem_req_ready = 1'b1;
                    if (exp_req.size() == 0) begin
                        chk("unexpected request", 32'd1, 32'd0);
                    end else begin
                        e = exp_req.pop_front();
                        chk("req addr", mem_addr, e.addr);
                        chk("req wen", {31'd0, mem_wen}, {31'd0, e.wen});
                        chk("req wstrb", {28'd0, mem_wstrb}, {28'd0, e.wstrb});
                        if (e.chk_wdata) chk("req wdata", mem_wdata, e.wdata);
                    end
                end
                wait_cnt++;
            end
            if (rsp_pend) begin
                rsp_cnt++;
                if (rsp_cnt >= rsp_delay) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_rdata = rsp_data;
                    mem_rsp_err   = rsp_err;
                    rsp_pend = 0;
                end
            end
        end
    end

    // WBU side: optional back-pressure, packet stability, scoreboard compare at acceptance.
    initial begin
        int   stall_cnt;
        bit   seen;
        out_t hold;
        out_t e;
        stall_cnt = 0; seen = 0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (out_ready) begin
                out_ready = 1'b0;
                stall_cnt = 0;
                seen = 0;
                n_done++;
            end else if (out_valid && !rst) begin
                if (!seen) begin
                    hold.data = wb_data; hold.rd = wb_addr; hold.wen = wb_wen; hold.fault = lsu_fault;
                    seen = 1;
                end else begin
                    chk("out hold data", wb_data, hold.data);
                    chk("out hold fault", {31'd0, lsu_fault}, {31'd0, hold.fault});
                end
                if (stall_cnt >= out_stall) begin
                    out_ready = 1'b1;
                    if (exp_out.size() == 0) begin
                        chk("unexpected packet", 32'd1, 32'd0);
                    end else begin
                        e = exp_out.pop_front();
                        chk("wb_addr", {27'd0, wb_addr}, {27'd0, e.rd});
                        chk("wb_wen", {31'd0, wb_wen}, {31'd0, e.wen});
                        chk("lsu_fault", {31'd0, lsu_fault}, {31'd0, e.fault});
                        if (e.chk_data) chk("wb_data", wb_data, e.data);
                    end
                end
                stall_cnt++;
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [4:0] rd, input logic wen,
                         input int lat, input bit wait_done);
        int n;
        int target;
        target = n_done + 1;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("in_ready before issue", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_mem_op = op; in_funct3 = f3;
        in_alu_result = alu; in_store_data = sd; in_rd = rd; in_wen = wen;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (lat > 0) begin
            n = 1;
            while (!out_valid && n < 30) begin @(posedge clk); #1; n++; end
            chk("out latency", n, lat);
        end
        if (wait_done) begin
            n = 0;
            while (n_done < target && n < 100) begin @(posedge clk); #1; n++; end
            chk("packet completed", {31'd0, n_done >= target}, 32'd1);
        end
    endtask

    task automatic push_out(input logic [31:0] d, input logic [4:0] rd, input logic wen,
                            input logic fault, input logic cd);
        out_t o;
        o.data = d; o.rd = rd; o.wen = wen; o.fault = fault; o.chk_data = cd;
        exp_out.push_back(o);
    endtask

    task automatic push_req(input logic [31:0] a, input logic wen, input logic [31:0] wd,
                            input logic [3:0] st, input logic cw);
        req_t r;
        r.addr = a; r.wen = wen; r.wdata = wd; r.wstrb = st; r.chk_wdata = cw;
        exp_req.push_back(r);
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata,
                           input logic [4:0] rd, input logic [31:0] exp);
        rsp_data = rdata;
        push_req(a, 1'b0, '0, 4'b0000, 1'b0);
        push_out(exp, rd, rd != 5'd0, 1'b0, 1'b1);
        issue(2'b01, f3, a, 32'h0, rd, 1'b1, 3, 1);
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] wd, input logic [3:0] st);
        push_req(a, 1'b1, wd, st, 1'b1);
        push_out('0, 5'd3, 1'b0, 1'b0, 1'b0);
        issue(2'b10, f3, a, d, 5'd3, 1'b1, 3, 1);
    endtask

    task automatic do_fault(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a);
        push_out('0, 5'd6, 1'b0, 1'b1, 1'b0);
        issue(op, f3, a, 32'h1111_2222, 5'd6, 1'b1, 1, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_mem_op = '0; in_funct3 = '0;
        in_alu_result = '0; in_store_data = '0; in_rd = '0; in_wen = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("reset wb_wen", {31'd0, wb_wen}, 32'd0);
        chk("reset lsu_fault", {31'd0, lsu_fault}, 32'd0);
        chk("reset wb_data", wb_data, 32'd0);
        chk("reset wb_addr", {27'd0, wb_addr}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Pass-through instructions
        push_out(32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b1);
        issue(2'b00, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1, 1);
        push_out(32'h0000_0042, 5'd0, 1'b0, 1'b0, 1'b1);
        issue(2'b00, 3'b000, 32'h0000_0042, 32'h0, 5'd0, 1'b1, 1, 1);
        push_out(32'hA5A5_0001, 5'd9, 1'b1, 1'b0, 1'b1);
        issue(2'b11, 3'b010, 32'hA5A5_0001, 32'h0, 5'd9, 1'b1, 1, 1);
        push_out(32'h0000_0077, 5'd4, 1'b0, 1'b0, 1'b1);
        issue(2'b00, 3'b000, 32'h0000_0077, 32'h0, 5'd4, 1'b0, 1, 1);

        // Loads
        do_load(3'b000, 32'h8000_0003, 32'h80FF_0000, 5'd7, 32'hFFFF_FF80);
        do_load(3'b100, 32'h8000_0003, 32'h80FF_0000, 5'd7, 32'h0000_0080);
        do_load(3'b001, 32'h8000_0002, 32'h8001_1234, 5'd8, 32'hFFFF_8001);
        do_load(3'b101, 32'h8000_0002, 32'h8001_1234, 5'd8, 32'h0000_8001);
        do_load(3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 5'd10, 32'hDEAD_BEEF);
        do_load(3'b000, 32'h8000_0001, 32'h0000_7F00, 5'd11, 32'h0000_007F);
        do_load(3'b101, 32'h8000_0000, 32'hFFFF_C0DE, 5'd12, 32'h0000_C0DE);
        do_load(3'b010, 32'h8000_0008, 32'h1234_5678, 5'd0, 32'h1234_5678);

        // Stores
        do_store(3'b001, 32'h8000_0002, 32'hABCD_1234, 32'h1234_1234, 4'b1100);
        do_store(3'b000, 32'h8000_0001, 32'h1122_3355, 32'h5555_5555, 4'b0010);
        do_store(3'b000, 32'h8000_0003, 32'h0000_00E7, 32'hE7E7_E7E7, 4'b1000);
        do_store(3'b010, 32'h8000_0010, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111);

        // Misaligned / illegal funct3: no request, packet on the next cycle
        do_fault(2'b01, 3'b010, 32'h8000_0001);
        do_fault(2'b01, 3'b001, 32'h8000_0003);
        do_fault(2'b10, 3'b010, 32'h8000_0002);
        do_fault(2'b01, 3'b011, 32'h8000_0000);
        do_fault(2'b10, 3'b100, 32'h8000_0000);

        // Slow bus + bus error + WBU back-pressure
        req_delay = 5; rsp_err = 1'b1; out_stall = 3; rsp_data = 32'h0BAD_0BAD;
        push_req(32'h8000_0020, 1'b0, '0, 4'b0000, 1'b0);
        push_out('0, 5'd13, 1'b0, 1'b1, 1'b0);
        issue(2'b01, 3'b010, 32'h8000_0020, 32'h0, 5'd13, 1'b1, 0, 1);
        req_delay = 0; rsp_err = 1'b0; out_stall = 0;

        // Reset while waiting for the response; the late response must be ignored
        rsp_delay = 2;
        push_req(32'h8000_0100, 1'b0, '0, 4'b0000, 1'b0);
        issue(2'b01, 3'b010, 32'h8000_0100, 32'h0, 5'd14, 1'b1, 0, 0);
        @(posedge clk); #1;
        chk("in WAIT mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("in WAIT out_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("after rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("after rst wb_wen", {31'd0, wb_wen}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("late rsp out_valid", {31'd0, out_valid}, 32'd0);
            chk("late rsp in_ready", {31'd0, in_ready}, 32'd1);
        end
        rsp_delay = 1;

        push_out(32'h0000_BEEF, 5'd15, 1'b1, 1'b0, 1'b1);
        issue(2'b00, 3'b000, 32'h0000_BEEF, 32'h0, 5'd15, 1'b1, 1, 1);
        do_load(3'b001, 32'h8000_0000, 32'h0000_7FFF, 5'd16, 32'h0000_7FFF);

        repeat (3) @(posedge clk);
        chk("scoreboard out drained", exp_out.size(), 32'd0);
        chk("scoreboard req drained", exp_req.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
